// File: rtl/pio_pkg.sv
// Shared constants for the debounced PIO: bus width and register word addresses.
package pio_pkg;

    localparam int BUS_W = 32;

    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd6;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd7;

endpackage

// File: rtl/pio_debounce.sv
// One input channel: 2-flop synchroniser, optional debounce counter (PIO_DEBOUNCE_EN),
// stable value and single-cycle rise/fall pulses coincident with the stable-value update.
module pio_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable,
    output logic rise,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;

    if (DEB_CYCLES < 1) begin : g_deb_check
        $error("DEB_CYCLES must be at least 1");
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic             stable_q;
    logic             flip;

    // The counter stops at CNT_MAX; the next differing cycle flips the stable value.
    assign flip = (sync_p1 != stable_q) && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            stable_q <= 1'b0;
        end else if (sync_p1 == stable_q) begin
            cnt <= '0;
        end else if (flip) begin
            cnt      <= '0;
            stable_q <= sync_p1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign stable = stable_q;
    assign rise   = flip & sync_p1;
    assign fall   = flip & ~sync_p1;
`else
    assign stable = sync_p1;
    assign rise   = sync_p0 & ~sync_p1;
    assign fall   = ~sync_p0 & sync_p1;
`endif

endmodule

// File: rtl/pio_debounce_irq.sv
// Avalon-MM PIO with per-channel debounce, edge capture (RW1C) and a level interrupt.
// Define PIO_DEBOUNCE_EN to build the debounce counters; otherwise inputs are only synchronised.
module pio_debounce_irq
    import pio_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] pio_out
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] cap_clr;
    logic [BUS_W-1:0] rd_mux;

    if (WIDTH < 1 || WIDTH > BUS_W) begin : g_width_check
        $error("WIDTH must be in 1..32");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        pio_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .din   (pio_in[i]),
            .stable(stable[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    assign wdata   = writedata[WIDTH-1:0];
    assign cap_clr = (write && address == ADDR_EDGE_CAP) ? wdata : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA_IN:  rd_mux = BUS_W'(stable);
            ADDR_DATA_OUT: rd_mux = BUS_W'(data_out);
            ADDR_IRQ_MASK: rd_mux = BUS_W'(irq_mask);
            ADDR_EDGE_CAP: rd_mux = BUS_W'(edge_cap);
            ADDR_RISE_EN:  rd_mux = BUS_W'(rise_en);
            ADDR_FALL_EN:  rd_mux = BUS_W'(fall_en);
            default:       rd_mux = '0;
        endcase
    end

    // Reads sample pre-write register values; an edge set overrides a same-cycle W1C clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            readdata <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clr) | (rise & rise_en) | (fall & fall_en);
            if (write) begin
                case (address)
                    ADDR_DATA_OUT: data_out <= wdata;
                    ADDR_IRQ_MASK: irq_mask <= wdata;
                    ADDR_OUT_SET:  data_out <= data_out | wdata;
                    ADDR_OUT_CLR:  data_out <= data_out & ~wdata;
                    ADDR_RISE_EN:  rise_en  <= wdata;
                    ADDR_FALL_EN:  fall_en  <= wdata;
                    default:       ;
                endcase
            end
            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

    assign irq     = |(edge_cap & irq_mask);
    assign pio_out = data_out;

endmodule

// File: doc/pio_debounce_irq.md
PIO_DEBOUNCE_IRQ -- requirements
Module: pio_debounce_irq

Interface
REQ-001 Parameter WIDTH, default 8: number of input and output channels, legal range 1..32.
REQ-002 Parameter DEB_CYCLES, default 50000: debounce qualification length in clk cycles, minimum 1.
REQ-003 Port clk, input, 1: sole clock.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port address, input, 3: Avalon-MM word address.
REQ-006 Port read, input, 1: Avalon-MM read strobe.
REQ-007 Port write, input, 1: Avalon-MM write strobe.
REQ-008 Port writedata, input, 32: Avalon-MM write data.
REQ-009 Port readdata, output, 32: Avalon-MM read data, fixed read latency 1.
REQ-010 Port irq, output, 1: level interrupt, active-high.
REQ-011 Port pio_in, input, WIDTH: asynchronous button/switch inputs.
REQ-012 Port pio_out, output, WIDTH: LED/output drive.

Function
REQ-013 Register map SHALL be: 0 DATA_IN (RO), 1 DATA_OUT (RW), 2 IRQ_MASK (RW), 3 EDGE_CAP (RW1C), 4 OUT_SET (WO), 5 OUT_CLR (WO), 6 RISE_EN (RW), 7 FALL_EN (RW).
REQ-014 Register bits above WIDTH-1 SHALL read 0 and SHALL ignore writes.
REQ-015 Reads of write-only addresses 4 and 5 SHALL return 0.
REQ-016 Each pio_in bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-017 Each debounce channel SHALL hold a stable value and a counter.
REQ-018 When the synchronised bit differs from the stable value for DEB_CYCLES consecutive cycles, the stable value SHALL flip on the next edge.
REQ-019 Any cycle in which the synchronised bit equals the stable value SHALL clear the counter.
REQ-020 Counter width SHALL be $clog2(DEB_CYCLES+1), and the counter SHALL never wrap.
REQ-021 DATA_IN SHALL return the stable (debounced) values.
REQ-022 A 0->1 stable transition on bit i SHALL set EDGE_CAP[i] when RISE_EN[i]=1; a 1->0 transition SHALL set it when FALL_EN[i]=1.
REQ-023 Writing 1 to EDGE_CAP[i] SHALL clear that bit; writing 0 SHALL leave it unchanged.
REQ-024 When an edge set and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-025 irq SHALL equal OR-reduce(EDGE_CAP & IRQ_MASK) taken directly from registers, with no extra latency.
REQ-026 OUT_SET write SHALL perform DATA_OUT |= writedata; OUT_CLR write SHALL perform DATA_OUT &= ~writedata.
REQ-027 pio_out SHALL equal DATA_OUT, updating on the clk edge after the write.
REQ-028 readdata SHALL be registered, valid in the cycle after read=1, and held at its last value otherwise.
REQ-029 Simultaneous read and write to the same address SHALL return the pre-write value.

Reset
REQ-030 On reset, the following SHALL clear to 0: DATA_OUT, IRQ_MASK, EDGE_CAP, RISE_EN, FALL_EN, readdata, irq, pio_out, synchroniser flops, stable values and counters.
REQ-031 Reset asserted mid-debounce SHALL discard partial counts; no edge SHALL be captured in the first cycle after reset deasserts.

Configuration
REQ-032 Macro PIO_DEBOUNCE_EN defined: debounce per REQ-017 to REQ-020.
REQ-033 Macro PIO_DEBOUNCE_EN undefined: no counters are built, DEB_CYCLES is ignored, and the stable value is the synchroniser output (2-cycle input latency).

Structure
REQ-034 Package pio_pkg SHALL hold register address localparams (ADDR_DATA_IN..ADDR_FALL_EN) and the data-bus width constant 32.
REQ-035 Sub-module pio_debounce (one channel: synchroniser, counter, stable value, rise/fall pulses) SHALL be instantiated WIDTH times via generate.

Verification
REQ-036 DEB_CYCLES=4: pio_in[0] 0->1 held 10 cycles -> DATA_IN[0]=1 exactly 2+4+1 cycles after the change; EDGE_CAP[0] set only if RISE_EN[0]=1.
REQ-037 DEB_CYCLES=4: pio_in[1] pulses high for 3 cycles, then low -> DATA_IN[1] stays 0 and EDGE_CAP stays 0x00.
REQ-038 RISE_EN=0xFF, IRQ_MASK=0x01, edge on bit 0 -> irq=1; write EDGE_CAP=0x01 -> irq=0 next cycle; edge landing in the same cycle as that write -> EDGE_CAP[0] stays 1.
REQ-039 DATA_OUT=0x0F; OUT_SET 0x30 -> pio_out=0x3F; OUT_CLR 0x03 -> pio_out=0x3C; read address 4 -> 0.
REQ-040 WIDTH=3: write 0xFFFFFFFF to IRQ_MASK -> reads back 0x00000007.
REQ-041 Reset pulsed with counter at 3 of 4 -> all registers 0, irq=0; input held high afterwards -> edge captured only after a full 2+4 cycles.
